pwm_array: RTL

Parametrised multi-channel PWM generator; successor to the fixed 16-channel/8-bit PWM peripheral. It sits between the SPI register bank and the pad outputs. It drives CHANNELS outputs from one shared prescaled timebase. Each channel has its own duty cycle. Duty updates are double-buffered and commit only at a period boundary, so outputs never glitch.

---
 rtl/pwm_array_pkg.sv | 19 +
 rtl/pwm_timebase.sv | 86 ++++++++
 rtl/pwm_array.sv | 78 +++++++
 3 files changed

// File: rtl/pwm_array_pkg.sv
// Shared types and helpers for the pwm_array PWM generator.
// PWM_CENTER_ALIGNED_EN selects the up/down counter mode in pwm_timebase.
package pwm_array_pkg;

   typedef enum logic {
      DirUp   = 1'b0,
      DirDown = 1'b1
   } dir_e;

   // Largest duty value; edge-aligned counting stops one short of it.
   function automatic int unsigned max_count(input int unsigned res);
      return (32'd1 << res) - 32'd1;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter; flags the period boundary tick.
// Define PWM_CENTER_ALIGNED_EN for up/down counting (period of 2*MAX ticks).
module pwm_timebase
   import pwm_array_pkg::*;
#(
   parameter int unsigned RES        = 8,
   parameter int unsigned PRESCALE_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic [RES-1:0]        cnt_o,
   output logic                  boundary_o
);

   localparam logic [RES-1:0] MaxCnt  = RES'(max_count(RES));
   localparam logic [RES-1:0] LastCnt = MaxCnt - RES'(1);

   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [RES-1:0]        cnt_q, cnt_d;
   logic                  tick;

   // >= so that lowering prescale below pre_cnt ticks on the next cycle
   always_comb begin
      tick      = (pre_cnt_q >= prescale_i);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
   end

`ifdef PWM_CENTER_ALIGNED_EN
   dir_e dir_q, dir_d;

   always_comb begin
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      boundary_o = 1'b0;
      if (tick) begin
         if (dir_q == DirUp) begin
            cnt_d = cnt_q + RES'(1);
            if (cnt_q == LastCnt) begin
               dir_d = DirDown;
            end
         end else begin
            cnt_d = cnt_q - RES'(1);
            if (cnt_q == RES'(1)) begin
               dir_d      = DirUp;
               boundary_o = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q <= DirUp;
      end else begin
         dir_q <= dir_d;
      end
   end
`else
   always_comb begin
      cnt_d      = cnt_q;
      boundary_o = 1'b0;
      if (tick) begin
         if (cnt_q == LastCnt) begin
            cnt_d      = '0;
            boundary_o = 1'b1;
         end else begin
            cnt_d = cnt_q + RES'(1);
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
         cnt_q     <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM with double-buffered duties committed at the period boundary.
// PWM_CENTER_ALIGNED_EN (see pwm_timebase) switches to center-aligned counting.
module pwm_array
   import pwm_array_pkg::*;
#(
   parameter int unsigned CHANNELS   = 16,
   parameter int unsigned RES        = 8,
   parameter int unsigned PRESCALE_W = 12
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [CHANNELS-1:0]                en_out,
   input  logic [CHANNELS-1:0]                en_pwm,
   input  logic [PRESCALE_W-1:0]              prescale,
   input  logic                               duty_we,
   input  logic [idx_width(CHANNELS)-1:0]     duty_ch,
   input  logic [RES-1:0]                     duty_data,
   output logic [CHANNELS-1:0]                pwm_out,
   output logic                               period_tick
);

   localparam int unsigned IdxW = idx_width(CHANNELS);

   logic [RES-1:0]      cnt;
   logic                boundary;
   logic [RES-1:0]      shadow_q [CHANNELS];
   logic [RES-1:0]      shadow_d [CHANNELS];
   logic [RES-1:0]      active_q [CHANNELS];
   logic [RES-1:0]      active_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                period_tick_q;

   pwm_timebase #(
      .RES        (RES),
      .PRESCALE_W (PRESCALE_W)
   ) u_timebase (
      .clk        (clk),
      .rst_n      (rst_n),
      .prescale_i (prescale),
      .cnt_o      (cnt),
      .boundary_o (boundary)
   );

   // Active loads from shadow_d so a write on the boundary cycle commits at once.
   // Out-of-range duty_ch values never match an index and are dropped.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         shadow_d[i] = shadow_q[i];
         if (duty_we && (duty_ch == IdxW'(i))) begin
            shadow_d[i] = duty_data;
         end
         active_d[i] = boundary ? shadow_d[i] : active_q[i];
         pwm_d[i]    = en_out[i] & (~en_pwm[i] | (cnt < active_q[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         pwm_q         <= '0;
         period_tick_q <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
         pwm_q         <= pwm_d;
         period_tick_q <= boundary;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_tick = period_tick_q;

endmodule
